// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - sequential multiply/divide unit with HI/LO registers and pipeline stall
// Results are computed at the start edge and held. HI/LO are released after a fixed busy countdown.
module mdu_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        id_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic        r_div0;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic        w_ovf;
  logic        w_bzero;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'd0, a} * {32'd0, b};
  assign w_bzero  = (b == 32'd0);
  // Most-negative / -1 overflows the signed quotient; pin it rather than trust the divider.
  assign w_ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign w_sq     = w_bzero ? 32'sd0 : ($signed(a) / $signed(b));
  assign w_sr     = w_bzero ? 32'sd0 : ($signed(a) % $signed(b));

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (op)
      3'd0: {w_res_hi, w_res_lo} = w_prod_s;
      3'd1: {w_res_hi, w_res_lo} = w_prod_u;
      3'd2: begin
        w_res_lo = w_ovf ? 32'h8000_0000 : w_sq;
        w_res_hi = w_ovf ? 32'd0 : w_sr;
      end
      3'd3: begin
        w_res_lo = w_bzero ? 32'd0 : (a / b);
        w_res_hi = w_bzero ? 32'd0 : (a % b);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_div0   <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                r_state  <= S_RUN;
                r_cnt    <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                r_res_hi <= w_res_hi;
                r_res_lo <= w_res_lo;
                r_div0   <= op[1] & w_bzero;
              end
              3'd4: hi <= a;
              3'd5: lo <= a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            if (!r_div0) begin
              hi <= r_res_hi;
              lo <= r_res_lo;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (r_state == S_RUN);
  assign stall = id_md_use & (busy | (start & ~op[2]));

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - scoreboard bench for mdu_seq
// Expected HI/LO are pushed when an op is issued and popped when busy falls.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        id_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] pre_hi;
  logic [31:0] pre_lo;

  mdu_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .id_md_use(id_md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] cur);
    logic [31:0] mx, my, q, r;
    logic [63:0] p;
    mx = x[31] ? -x : x;
    my = y[31] ? -y : y;
    case (o)
      3'd0: begin p = {32'd0, mx} * {32'd0, my}; return (x[31] ^ y[31]) ? -p : p; end
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) return cur;
        q = mx / my; r = mx % my;
        if (x[31] ^ y[31]) q = -q;
        if (x[31]) r = -r;
        return {r, q};
      end
      3'd3: begin if (y == 0) return cur; return {x % y, x / y}; end
      default: return cur;
    endcase
  endfunction

  task automatic drive_start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    pre_hi = hi; pre_lo = lo;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
  endtask

  task automatic finish_op(input int pre, input int exp_cyc, input string name);
    int cyc;
    bit stable;
    logic [63:0] e;
    cyc = pre; stable = 1'b1;
    while (busy && cyc < 200) begin
      if (hi !== pre_hi || lo !== pre_lo) stable = 1'b0;
      cyc++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (cyc !== exp_cyc) begin
      n_bad++; $display("FAIL %s busy_cycles got %0d want %0d", name, cyc, exp_cyc);
    end
    n_cmp++;
    if (!stable) begin
      n_bad++; $display("FAIL %s hilo_early got changed want held at %h_%h", name, pre_hi, pre_lo);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++; $display("FAIL %s scoreboard got empty want entry", name);
    end else begin
      e = exp_q.pop_front();
      if ({hi, lo} !== e) begin
        n_bad++; $display("FAIL %s hilo got %h_%h want %h_%h", name, hi, lo, e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 3'd7; a = 0; b = 0; id_md_use = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin
      n_bad++; $display("FAIL reset_state got busy=%b hi=%h lo=%h stall=%b want 0/0/0/0", busy, hi, lo, stall);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mult();
    drive_start(3'd0, 32'hFFFF_FFFE, 32'd3);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    finish_op(0, 5, "mult");
    drive_start(3'd1, 32'hFFFF_FFFE, 32'd3);
    exp_q.push_back({32'h0000_0002, 32'hFFFF_FFFA});
    finish_op(0, 5, "multu");
  endtask

  task automatic test_div();
    drive_start(3'd2, 32'hFFFF_FFF9, 32'd2);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    finish_op(0, 10, "div_neg");
    drive_start(3'd3, 32'd7, 32'd0);
    exp_q.push_back({pre_hi, pre_lo});
    finish_op(0, 10, "divu_zero");
  endtask

  task automatic test_overflow();
    drive_start(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    exp_q.push_back({32'h0000_0000, 32'h8000_0000});
    a = 32'd100; b = 32'd7;
    finish_op(0, 10, "div_ovf");
  endtask

  task automatic test_stall();
    bit ok;
    for (int u = 1; u >= 0; u--) begin
      id_md_use = u[0];
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
      pre_hi = hi; pre_lo = lo;
      #1;
      n_cmp++;
      if (stall !== u[0]) begin
        n_bad++; $display("FAIL stall_start use=%0d got %b want %b", u, stall, u[0]);
      end
      exp_q.push_back(64'd42);
      @(posedge clk); #1;
      start = 1'b0; op = 3'd7;
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
        if (stall !== u[0] || busy !== 1'b1) ok = 1'b0;
        if (k < 4) begin @(posedge clk); #1; end
      end
      n_cmp++;
      if (!ok) begin
        n_bad++; $display("FAIL stall_busy use=%0d got mismatch want stall=%b busy=1 for 5 cycles", u, u[0]);
      end
      finish_op(4, 5, "stall_mult");
      n_cmp++;
      if (stall !== 1'b0) begin
        n_bad++; $display("FAIL stall_after use=%0d got %b want 0", u, stall);
      end
    end
    id_md_use = 1'b0;
  endtask

  task automatic test_mthi();
    drive_start(3'd2, 32'd10, 32'd3);
    exp_q.push_back({32'd1, 32'd3});
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    finish_op(1, 10, "mthi_in_run");
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    n_cmp++;
    if (hi !== 32'h1234_5678 || lo !== 32'd3 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mthi_idle got hi=%h lo=%h busy=%b want 12345678/3/0", hi, lo, busy);
    end
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    n_cmp++;
    if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_F00D || busy !== 1'b0) begin
      n_bad++; $display("FAIL mtlo_idle got hi=%h lo=%h busy=%b want 12345678/cafef00d/0", hi, lo, busy);
    end
    for (int o = 6; o <= 7; o++) begin
      @(negedge clk);
      start = 1'b1; op = 3'(o); a = 32'h5555_5555; b = 32'd2;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd7;
      n_cmp++;
      if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_F00D || busy !== 1'b0) begin
        n_bad++; $display("FAIL nop_op%0d got hi=%h lo=%h busy=%b want unchanged, busy 0", o, hi, lo, busy);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    drive_start(3'd0, 32'd5, 32'd7);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++; $display("FAIL reset_abort got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk); reset = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL reset_late_write got hi=%h lo=%h want 0/0", hi, lo);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    pre_hi = 32'd0; pre_lo = 32'd0;
    exp_q.push_back(64'd12);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7;
    finish_op(0, 5, "first_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 4 == 1) x = -x;
      if (y == 0) y = 32'd1;
      drive_start(o, x, y);
      exp_q.push_back(model(o, x, y, {pre_hi, pre_lo}));
      finish_op(0, o[1] ? 10 : 5, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_overflow();
    test_stall();
    test_mthi();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter MULT_CYCLES, default 5, SHALL set the busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, SHALL set the busy cycles for div/divu.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be the EX-stage request strobe, sampled at the rising clk edge.
REQ-006 op  input  3  SHALL encode 0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo; 6 and 7 are no-ops.
REQ-007 a  input  32  SHALL be operand rs (dividend/multiplicand; source for mthi/mtlo).
REQ-008 b  input  32  SHALL be operand rt (divisor/multiplier).
REQ-009 id_md_use  input  1  SHALL flag that the ID-stage instruction touches HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 busy  output  1  SHALL be high while an operation is in flight.
REQ-011 stall  output  1  SHALL be the freeze request to PC/ID and bubble request to EX.
REQ-012 hi  output  32  SHALL be the current HI register.
REQ-013 lo  output  32  SHALL be the current LO register.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and RUN, plus a countdown counter of at least 4 bits.
REQ-015 In IDLE, start with op in {0..3} SHALL enter RUN and load the counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
REQ-016 The result SHALL be computed from a/b sampled at the start edge and held in internal result registers; later a/b changes SHALL NOT affect it.
REQ-017 In RUN the counter SHALL decrement each edge; at the edge where it equals 1, hi/lo SHALL take the result and the FSM SHALL return to IDLE.
REQ-018 busy SHALL be high for exactly N cycles after the start edge (N=MULT_CYCLES or DIV_CYCLES); hi/lo SHALL change on the same edge that busy falls.
REQ-019 mult: {hi,lo} SHALL be the signed 64-bit product; multu: the unsigned product.
REQ-020 div/divu: lo SHALL be the quotient and hi the remainder; signed quotient truncates toward zero; remainder sign follows the dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-022 A divisor of zero SHALL still run DIV_CYCLES with busy high, but hi/lo SHALL remain unchanged at completion.
REQ-023 mthi/mtlo in IDLE SHALL write a into hi/lo at the start edge, with no busy cycle.
REQ-024 start during RUN SHALL be ignored, including mthi/mtlo; the counter, result and hi/lo are unaffected.
REQ-025 start with op 6 or 7 SHALL be ignored.
REQ-026 stall SHALL be combinational: stall = id_md_use & (busy | (start & op<=3)).
REQ-027 stall SHALL be low whenever id_md_use is low, even if busy is high.
REQ-028 On the completing edge, a new start arrives only after busy is low, i.e. the next cycle; back-to-back operations SHALL therefore have no gap beyond the stall.

Reset
REQ-029 reset high SHALL immediately force IDLE, counter=0, hi=0, lo=0, result registers=0 and busy=0, without waiting for a clk edge.
REQ-030 reset asserted mid-RUN SHALL abort the operation; no partial or late hi/lo write SHALL occur after reset is released.
REQ-031 After reset is released, the first start SHALL be accepted at the first rising edge.

Verification
REQ-032 mult a=0xFFFFFFFE, b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-033 div a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=0 -> after 10 cycles hi/lo unchanged.
REQ-034 mult, then id_md_use=1 held during RUN -> stall=1 on the start cycle and all 5 busy cycles, 0 on the next; with id_md_use=0 -> stall=0 throughout.
REQ-035 div started, then start with op=4 (mthi) a=0x12345678 on cycle 3 -> ignored; hi equals the remainder at completion; mthi in IDLE -> hi=0x12345678 at that edge, busy stays 0.
REQ-036 mult started, reset pulsed asynchronously at cycle 2 -> busy=0 and hi=lo=0 immediately; hi/lo stay 0 through the original completion time.
REQ-037 signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 after 10 cycles; operands changed on the cycle after start -> result unaffected.
